mem_writer: RTL

Sequential write port for the block-RAM operand store. On a one-cycle `start` it latches a `BITLEN`-wide operand (modulus, exponent or result word) and a base address, then writes the operand into RAM as `BITLEN/DBITS` consecutive `DBITS`-wide words. It pulses `done` when the last word is written. It is the write-side counterpart of the single-word memory reader and drives the RAM's write port, so the exponentiation core can store results back for later readout.

---
 rtl/mem_writer_if.sv | 26 ++
 rtl/mem_writer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mem_writer_if.sv
// Request/RAM-write bundle for mem_writer: operand request in, RAM write port
// and status out. The requester uses the master modport; the writer uses slave.
interface mem_writer_if #(
    parameter int ABITS  = 8,
    parameter int DBITS  = 16,
    parameter int BITLEN = 64
);
    logic              start;
    logic [ABITS-1:0]  base_addr;
    logic [BITLEN-1:0] in;
    logic              wr_en;
    logic [ABITS-1:0]  wr_addr;
    logic [DBITS-1:0]  wr_data;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, in,
        input  wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  start, base_addr, in,
        output wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/mem_writer.sv
// Sequential RAM write port: splits a BITLEN operand into DBITS words written
// to consecutive addresses. Define MEM_WRITER_MSW_FIRST_EN to write MSW first.
module mem_writer #(
    parameter int ABITS  = 8,
    parameter int DBITS  = 16,
    parameter int BITLEN = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_writer_if.slave  bus
);
    localparam int WORDS = BITLEN / DBITS;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [BITLEN-1:0] sreg_q, sreg_d;
    logic [ABITS-1:0]  addr_q, addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ABITS-1:0]  wr_addr_q, wr_addr_d;
    logic [DBITS-1:0]  wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DBITS-1:0]  chunk_s;
    logic [BITLEN-1:0] sreg_next_s;

    // Select the outgoing word and the shifted remainder for the configured order
    always_comb begin
`ifdef MEM_WRITER_MSW_FIRST_EN
        chunk_s     = sreg_q[BITLEN-1 -: DBITS];
        sreg_next_s = sreg_q << DBITS;
`else
        chunk_s     = sreg_q[DBITS-1:0];
        sreg_next_s = sreg_q >> DBITS;
`endif
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_WRITE;
                    sreg_d  = bus.in;
                    addr_d  = bus.base_addr;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                busy_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = chunk_s;
                // Address wraps naturally modulo 2^ABITS
                addr_d    = addr_q + ABITS'(1);
                sreg_d    = sreg_next_s;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST_WORD) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sreg_q    <= {BITLEN{1'b0}};
            addr_q    <= {ABITS{1'b0}};
            cnt_q     <= {CW{1'b0}};
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ABITS{1'b0}};
            wr_data_q <= {DBITS{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
